// File: rtl/bram_packet_reader_pkg.sv
// Shared definitions for the BRAM packet reader: ring geometry, packet layout,
// header magic words, FSM state encoding and the skid-buffer beat payload.
package bram_packet_reader_pkg;

    localparam int unsigned ADDR_W_DEF = 14;
    localparam int unsigned RING_WORDS = 2 ** ADDR_W_DEF;
    localparam int unsigned HDR_WORDS  = 4;
    localparam int unsigned PKT_WORDS  = HDR_WORDS + 35 * 4;
    localparam int unsigned DATA_W     = 32;

    localparam logic [DATA_W-1:0] MAGIC_LOW  = 32'hDEAD_BEEF;
    localparam logic [DATA_W-1:0] MAGIC_HIGH = 32'hCAFE_BABE;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              last;
    } beat_t;

endpackage

// File: rtl/bram_packet_reader_skid.sv
// axis_skid_buf: 2-entry AXI-Stream buffer. The head entry drives the master
// side directly from registers; the tail entry absorbs one beat while the
// head is stalled.
// Ports: clk, rstn (async active-low), s_beat/s_tvalid/s_tready (input side),
//        m_beat/m_tvalid/m_tready (output side), level (entries occupied).
module axis_skid_buf
    import bram_packet_reader_pkg::*;
(
    input  logic       clk,
    input  logic       rstn,
    input  beat_t      s_beat,
    input  logic       s_tvalid,
    output logic       s_tready,
    output beat_t      m_beat,
    output logic       m_tvalid,
    input  logic       m_tready,
    output logic [1:0] level
);

    beat_t head_q;
    beat_t tail_q;
    logic  head_vld_q;
    logic  tail_vld_q;
    logic  push;
    logic  pop;

    assign s_tready = ~tail_vld_q;
    assign push     = s_tvalid & s_tready;
    assign pop      = head_vld_q & m_tready;
    assign m_beat   = head_q;
    assign m_tvalid = head_vld_q;
    assign level    = 2'(head_vld_q) + 2'(tail_vld_q);

    // Head/tail occupancy update; the tail only fills while the head is stalled.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            head_q     <= '0;
            tail_q     <= '0;
            head_vld_q <= 1'b0;
            tail_vld_q <= 1'b0;
        end else if (!head_vld_q) begin
            if (push) begin
                head_q     <= s_beat;
                head_vld_q <= 1'b1;
            end
        end else if (!tail_vld_q) begin
            if (pop && push) begin
                head_q <= s_beat;
            end else if (pop) begin
                head_vld_q <= 1'b0;
            end else if (push) begin
                tail_q     <= s_beat;
                tail_vld_q <= 1'b1;
            end
        end else if (pop) begin
            head_q     <= tail_q;
            tail_vld_q <= 1'b0;
        end
    end

endmodule

// File: rtl/bram_packet_reader.sv
// bram_packet_reader: drains fixed-size packets from a BRAM ring buffer
// (port B) onto an AXI-Stream master, tracking committed-but-unread packets.
// Ports: clk, rstn (async active-low), enable, wr_pkt_done, clear_status;
//        bram_addr/bram_en/bram_we/bram_dout (BRAM port B, byte address);
//        m_axis_tdata/tvalid/tready/tlast (stream out);
//        pkts_pending, pkts_read, overflow, sync_error (status).
// Build option: define READER_MAGIC_CHECK_EN to check header words 0/1
// against MAGIC_LOW/MAGIC_HIGH and flag sync_error; otherwise sync_error = 0.
// bram_en is decoded from registered state and the skid credit so a read can
// be issued in the same cycle credit frees up, giving 1 word/cycle.
module bram_packet_reader #(
    parameter int unsigned ADDR_W    = bram_packet_reader_pkg::ADDR_W_DEF,
    parameter int unsigned PKT_WORDS = bram_packet_reader_pkg::PKT_WORDS
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              enable,
    input  logic              wr_pkt_done,
    input  logic              clear_status,
    output logic [ADDR_W+1:0] bram_addr,
    output logic              bram_en,
    output logic [3:0]        bram_we,
    input  logic [31:0]       bram_dout,
    output logic [31:0]       m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast,
    output logic [7:0]        pkts_pending,
    output logic [31:0]       pkts_read,
    output logic              overflow,
    output logic              sync_error
);
    import bram_packet_reader_pkg::*;

    localparam int unsigned RING_W  = 2 ** ADDR_W;
    localparam int unsigned CAP     = RING_W / PKT_WORDS;
    localparam int unsigned WRAP_AT = RING_W - PKT_WORDS;
    localparam int unsigned CNT_W   = $clog2(PKT_WORDS + 1);

    state_t             state_q;
    state_t             state_d;
    logic [ADDR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]   rd_cnt_q;
    logic               rd_vld_q;
    logic               rd_last_q;
    logic [7:0]         pend_q;
    logic [31:0]        read_q;
    logic               ovf_q;
    logic               issue;
    logic               credit_ok;
    logic               pop;
    logic               last_hs;
    logic               pkt_inc;
    logic               skid_rdy;
    logic [1:0]         skid_level;
    logic [2:0]         occ;
    beat_t              s_beat;
    beat_t              m_beat;

    assign pop     = m_axis_tvalid & m_axis_tready;
    assign last_hs = pop & m_axis_tlast;
    assign pkt_inc = wr_pkt_done & (pend_q != 8'(CAP));

    // Words in flight from BRAM plus buffered words that survive this cycle.
    assign occ       = 3'(skid_level) + 3'(rd_vld_q) - 3'(pop);
    assign credit_ok = skid_rdy & (occ < 3'd2);

    assign bram_en      = issue;
    assign bram_addr    = {rd_ptr_q, 2'b00};
    assign bram_we      = 4'h0;
    assign pkts_pending = pend_q;
    assign pkts_read    = read_q;
    assign overflow     = ovf_q;

    // FSM state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next state and read issue.
    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enable && (pend_q != 8'd0)) state_d = ST_READ;
            end
            ST_READ: begin
                if (credit_ok) begin
                    issue = 1'b1;
                    if (rd_cnt_q == CNT_W'(PKT_WORDS - 1)) state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (last_hs) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Read pointer, per-packet read count and the BRAM return pipeline tag.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_ptr_q  <= '0;
            rd_cnt_q  <= '0;
            rd_vld_q  <= 1'b0;
            rd_last_q <= 1'b0;
        end else begin
            rd_vld_q  <= issue;
            rd_last_q <= issue & (rd_cnt_q == CNT_W'(PKT_WORDS - 1));
            if (state_q == ST_IDLE)  rd_cnt_q <= '0;
            else if (issue)          rd_cnt_q <= rd_cnt_q + CNT_W'(1);
            if (issue) begin
                rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
            end else if (last_hs && (rd_ptr_q >= ADDR_W'(WRAP_AT))) begin
                // No room for another whole packet before the ring end.
                rd_ptr_q <= '0;
            end
        end
    end

    // Packet accounting and sticky overflow (a new set beats a clear).
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pend_q <= '0;
            read_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            case ({pkt_inc, last_hs})
                2'b10:   pend_q <= pend_q + 8'd1;
                2'b01:   pend_q <= pend_q - 8'd1;
                default: pend_q <= pend_q;
            endcase
            read_q <= read_q + 32'(last_hs);
            ovf_q  <= (wr_pkt_done & ~pkt_inc) | (ovf_q & ~clear_status);
        end
    end

`ifdef READER_MAGIC_CHECK_EN
    logic [1:0] rd_hdr_q;
    logic       sync_q;
    logic       magic_bad;

    assign magic_bad = rd_vld_q & ((rd_hdr_q[0] & (bram_dout != MAGIC_LOW)) |
                                   (rd_hdr_q[1] & (bram_dout != MAGIC_HIGH)));
    assign sync_error = sync_q;

    // Tag header words 0/1 on their way back from BRAM and compare them.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_hdr_q <= 2'b00;
            sync_q   <= 1'b0;
        end else begin
            rd_hdr_q <= issue ? {rd_cnt_q == CNT_W'(1), rd_cnt_q == CNT_W'(0)} : 2'b00;
            sync_q   <= magic_bad | (sync_q & ~clear_status);
        end
    end
`else
    assign sync_error = 1'b0;
`endif

    assign s_beat = '{data: bram_dout, last: rd_last_q};

    axis_skid_buf u_skid (
        .clk      (clk),
        .rstn     (rstn),
        .s_beat   (s_beat),
        .s_tvalid (rd_vld_q),
        .s_tready (skid_rdy),
        .m_beat   (m_beat),
        .m_tvalid (m_axis_tvalid),
        .m_tready (m_axis_tready),
        .level    (skid_level)
    );

    assign m_axis_tdata = m_beat.data;
    assign m_axis_tlast = m_beat.last;

endmodule
